zero_cross_freq_est: RTL and testbench

- Sits directly downstream of the serial ADC controller.
- Consumes each 12-bit sample, qualified by the controller's end-of-sample level (`fim_amostra`).
- Detects rising crossings of mid-scale with hysteresis and counts samples between crossings.
- Averages 2^LOG2_AVG periods and publishes the mean period, in samples, for the frequency computation stage.

---
 rtl/freq_est_pkg.sv | 13 +
 rtl/strobe_rise_det.sv | 20 ++
 rtl/zero_cross_freq_est.sv | 139 +++++++++++++
 tb/tb_zero_cross_freq_est.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/freq_est_pkg.sv
// Shared definitions for the ADC sample-rate frequency estimation chain.
// The ADC controller wrapper and the frequency divider also use these constants.
package freq_est_pkg;

  localparam int ADC_W   = 12;
  localparam int ADC_MID = 2048;

  typedef enum logic {
    ST_IDLE,
    ST_MEASURE
  } stateT;

endpackage

// File: rtl/strobe_rise_det.sv
// Single-cycle accept pulse on the rising edge of a sample-ready level.
// The history bit resets high, so a level already high at reset release is ignored.
module strobe_rise_det (
  input  logic iCLK,
  input  logic iRST,
  input  logic iSTB,
  output logic oACCEPT
);

  logic hist;

  // NOTE: clocked state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge iCLK) begin
    if (iRST) hist <= 1'b1;
    else      hist <= iSTB;
  end

  assign oACCEPT = iSTB & ~hist;

endmodule

// File: rtl/zero_cross_freq_est.sv
// Mid-scale rising-crossing detector with hysteresis; averages 2^LOG2_AVG periods
// (in samples) and publishes the mean with a 2-cycle latency from the strobe rise.
module zero_cross_freq_est
  import freq_est_pkg::*;
#(
  parameter int DATA_W   = ADC_W,
  parameter int MID      = ADC_MID,
  parameter int HYST     = 64,
  parameter int LOG2_AVG = 3,
  parameter int CNT_W    = 16
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [DATA_W-1:0] iSAMPLE,
  input  logic              iSTB,
  output logic [CNT_W-1:0]  oPERIOD,
  output logic              oVALID,
  output logic              oTIMEOUT,
  output logic              oLOCK
);

  localparam int ACC_W = CNT_W + LOG2_AVG;
  localparam logic [DATA_W-1:0] HI_TH = DATA_W'(MID + HYST);
  localparam logic [DATA_W-1:0] LO_TH = DATA_W'(MID - HYST);
  // MAX_PERIOD-1: the last count a non-crossing sample may see before timeout
  localparam logic [CNT_W-1:0] CNT_LAST = {{(CNT_W-1){1'b1}}, 1'b0};

  logic                accept;
  logic                acceptQ;
  logic [DATA_W-1:0]   sampleQ;

  logic                lvl, lvlNxt;
  stateT               state, stateNxt;
  logic [CNT_W-1:0]    cnt, cntNxt;
  logic [ACC_W-1:0]    acc, accNxt;
  logic [LOG2_AVG-1:0] nper, nperNxt;
  logic [CNT_W-1:0]    periodNxt;
  logic                validNxt, timeoutNxt, lockNxt;

  logic                crossing;
  logic [CNT_W-1:0]    period;
  logic [ACC_W-1:0]    periodSum;

  strobe_rise_det uStrobe (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .iSTB    (iSTB),
    .oACCEPT (accept)
  );

  assign crossing  = acceptQ & ~lvl & (sampleQ >= HI_TH);
  assign period    = cnt + 1'b1;
  assign periodSum = acc + ACC_W'(period);

  // NOTE: every signal driven here gets a default first, so no path infers a latch.
  always_comb begin
    lvlNxt     = lvl;
    stateNxt   = state;
    cntNxt     = cnt;
    accNxt     = acc;
    nperNxt    = nper;
    periodNxt  = oPERIOD;
    lockNxt    = oLOCK;
    validNxt   = 1'b0;
    timeoutNxt = 1'b0;

    if (acceptQ) begin
      if (!lvl && sampleQ >= HI_TH)     lvlNxt = 1'b1;
      else if (lvl && sampleQ <= LO_TH) lvlNxt = 1'b0;
    end

    case (state)
      ST_IDLE: begin
        if (crossing) begin
          cntNxt   = '0;
          accNxt   = '0;
          nperNxt  = '0;
          stateNxt = ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        // A crossing is checked first so it wins over a coincident timeout.
        if (crossing) begin
          cntNxt = '0;
          if (nper == '1) begin
            periodNxt = periodSum[ACC_W-1:LOG2_AVG];
            validNxt  = 1'b1;
            lockNxt   = 1'b1;
            accNxt    = '0;
            nperNxt   = '0;
          end else begin
            accNxt  = periodSum;
            nperNxt = nper + 1'b1;
          end
        end else if (acceptQ) begin
          if (cnt == CNT_LAST) begin
            timeoutNxt = 1'b1;
            lockNxt    = 1'b0;
            accNxt     = '0;
            nperNxt    = '0;
            stateNxt   = ST_IDLE;
          end else begin
            cntNxt = cnt + 1'b1;
          end
        end
      end
      default: stateNxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      acceptQ  <= 1'b0;
      sampleQ  <= '0;
      lvl      <= 1'b0;
      state    <= ST_IDLE;
      cnt      <= '0;
      acc      <= '0;
      nper     <= '0;
      oPERIOD  <= '0;
      oVALID   <= 1'b0;
      oTIMEOUT <= 1'b0;
      oLOCK    <= 1'b0;
    end else begin
      acceptQ <= accept;
      if (accept) sampleQ <= iSAMPLE;
      lvl      <= lvlNxt;
      state    <= stateNxt;
      cnt      <= cntNxt;
      acc      <= accNxt;
      nper     <= nperNxt;
      oPERIOD  <= periodNxt;
      oVALID   <= validNxt;
      oTIMEOUT <= timeoutNxt;
      oLOCK    <= lockNxt;
    end
  end

endmodule

// File: tb/tb_zero_cross_freq_est.sv
// Directed bench: two instances (CNT_W=16 and CNT_W=8) share one stimulus stream;
// a table of sample segments carries the expected pulses, period and lock after each.
module tb_zero_cross_freq_est;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb;
  logic [11:0] sample;

  logic [15:0] periodA;
  logic        validA, toA, lockA;
  logic [7:0]  periodB;
  logic        validB, toB, lockB;

  always #5 clk = ~clk;

  zero_cross_freq_est #(.CNT_W(16)) dutA (
    .iCLK(clk), .iRST(rst), .iSAMPLE(sample), .iSTB(stb),
    .oPERIOD(periodA), .oVALID(validA), .oTIMEOUT(toA), .oLOCK(lockA)
  );

  zero_cross_freq_est #(.CNT_W(8)) dutB (
    .iCLK(clk), .iRST(rst), .iSAMPLE(sample), .iSTB(stb),
    .oPERIOD(periodB), .oVALID(validB), .oTIMEOUT(toB), .oLOCK(lockB)
  );

  typedef enum int {K_RUN, K_HOLD, K_RST} kindT;

  typedef struct {
    string name;
    kindT  kind;
    int    val;
    int    alt;
    int    reps;
    bit    onlyB;
    int    expValid;
    int    expTimeout;
    int    expPeriod;
    bit    expLock;
  } vecT;

  vecT vecs[$];
  int  total = 0;
  int  bad   = 0;
  int  nValidA = 0, nValidB = 0, nToA = 0, nToB = 0, nBoth = 0;
  int  ePer;
  bit  eLock;

  always @(negedge clk) begin
    if (validA) nValidA <= nValidA + 1;
    if (validB) nValidB <= nValidB + 1;
    if (toA)    nToA    <= nToA + 1;
    if (toB)    nToB    <= nToB + 1;
    if ((validA && toA) || (validB && toB)) nBoth <= nBoth + 1;
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic sendSample(input int v);
    sample = 12'(v);
    stb    = 1'b1;
    @(posedge clk); #1;
    stb    = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic holdSample(input int v);
    sample = 12'(v);
    stb    = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    stb    = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  function automatic void add(input string name, input kindT kind, input int val,
                              input int alt, input int reps, input bit onlyB,
                              input int ev, input int et, input int ep, input bit el);
    vecT v;
    v.name = name; v.kind = kind; v.val = val; v.alt = alt; v.reps = reps;
    v.onlyB = onlyB; v.expValid = ev; v.expTimeout = et; v.expPeriod = ep; v.expLock = el;
    vecs.push_back(v);
  endfunction

  // n periods: a low run then a 3000 run whose first sample is the crossing.
  function automatic void addPeriods(input string name, input int n, input bit trunc,
                                     input bit hyst, input bit onlyB, input int batchPer,
                                     input bit completes);
    for (int k = 1; k <= n; k++) begin
      bit done;
      done = completes && (k == n);
      if (hyst) begin
        add({name, "_band_hi"}, K_RUN, 2040, 2100, 10, onlyB, 0, 0, ePer, eLock);
        add({name, "_lo"},      K_RUN, 1000, 0,    10, onlyB, 0, 0, ePer, eLock);
        add({name, "_band_lo"}, K_RUN, 2040, 2100, 10, onlyB, 0, 0, ePer, eLock);
      end else begin
        add({name, "_lo"}, K_RUN, 1000, 0, 20, onlyB, 0, 0, ePer, eLock);
      end
      if (done) begin
        ePer  = batchPer;
        eLock = 1'b1;
      end
      add({name, "_hi"}, K_RUN, 3000, 0, (trunc && (k % 2 == 1)) ? 21 : 20, onlyB,
          done ? 1 : 0, 0, ePer, eLock);
    end
  endfunction

  initial begin
    int vA, vB, tA, tB;

    // Reset with the strobe already high; it must not be accepted on release.
    rst = 1'b1; stb = 1'b1; sample = 12'd3000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_periodA", periodA, 0);
    check("rst_validA",  validA,  0);
    check("rst_toA",     toA,     0);
    check("rst_lockA",   lockA,   0);
    check("rst_periodB", periodB, 0);
    check("rst_validB",  validB,  0);
    check("rst_toB",     toB,     0);
    check("rst_lockB",   lockB,   0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    stb = 1'b0;
    @(posedge clk); #1;
    check("stb_high_release_lock", lockA, 0);

    ePer = 0; eLock = 1'b0;
    add("pre", K_RUN, 1000, 0, 20, 0, 0, 0, 0, 0);
    add("arm", K_RUN, 3000, 0, 20, 0, 0, 0, 0, 0);
    addPeriods("avg1",  8, 0, 0, 0, 40, 1);
    addPeriods("avg2",  8, 0, 0, 0, 40, 1);
    addPeriods("trunc", 8, 1, 0, 0, 40, 1);
    addPeriods("hyst",  8, 0, 1, 0, 50, 1);
    addPeriods("mid",   5, 0, 0, 0, 0,  0);
    ePer = 0; eLock = 1'b0;
    add("mid_reset",   K_RST, 0,    0, 0,  0, 0, 0, 0, 0);
    add("rearm_lo",    K_RUN, 1000, 0, 20, 0, 0, 0, 0, 0);
    add("rearm_hi",    K_RUN, 3000, 0, 20, 0, 0, 0, 0, 0);
    addPeriods("post_rst", 8, 0, 0, 0, 40, 1);
    // After the last crossing cnt=19; the 236th constant sample sees cnt=254.
    add("to_run1",  K_RUN,  3000, 0, 100, 1, 0, 0, 40, 1);
    add("to_hold",  K_HOLD, 3000, 0, 1,   1, 0, 0, 40, 1);
    add("to_run2",  K_RUN,  3000, 0, 134, 1, 0, 0, 40, 1);
    eLock = 1'b0;
    add("to_hit",   K_RUN,  3000, 0, 1,   1, 0, 1, 40, 0);
    add("re2_lo",   K_RUN,  1000, 0, 20,  1, 0, 0, 40, 0);
    add("re2_hi",   K_RUN,  3000, 0, 20,  1, 0, 0, 40, 0);
    addPeriods("relock", 8, 0, 0, 1, 40, 1);

    foreach (vecs[i]) begin
      vA = nValidA; vB = nValidB; tA = nToA; tB = nToB;
      case (vecs[i].kind)
        K_RUN:
          for (int j = 0; j < vecs[i].reps; j++)
            sendSample((vecs[i].alt != 0 && (j % 2 == 1)) ? vecs[i].alt : vecs[i].val);
        K_HOLD: holdSample(vecs[i].val);
        default: pulseReset();
      endcase
      @(posedge clk); #1;
      if (!vecs[i].onlyB) begin
        check({vecs[i].name, "_validA"},  nValidA - vA, vecs[i].expValid);
        check({vecs[i].name, "_toA"},     nToA - tA,    vecs[i].expTimeout);
        check({vecs[i].name, "_periodA"}, periodA,      vecs[i].expPeriod);
        check({vecs[i].name, "_lockA"},   lockA,        vecs[i].expLock);
      end
      check({vecs[i].name, "_validB"},  nValidB - vB, vecs[i].expValid);
      check({vecs[i].name, "_toB"},     nToB - tB,    vecs[i].expTimeout);
      check({vecs[i].name, "_periodB"}, periodB,      vecs[i].expPeriod);
      check({vecs[i].name, "_lockB"},   lockB,        vecs[i].expLock);
    end

    check("valid_timeout_exclusive", nBoth, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
